// File: rtl/dot_prod_sched.sv
// Round-robin scheduler sharing one dot_prod engine between NREQ requesters.
// Holds the engine in reset while idle and releases it for exactly one job per grant.
module dot_prod_sched #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned NROW     = 16,
    parameter int unsigned NCOL     = 4,
    parameter int unsigned BITWIDTH = 18,
    parameter int unsigned TIMEOUT  = 256,
    localparam int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int unsigned COL_W   = (NCOL > 1) ? $clog2(NCOL) : 1,
    localparam int unsigned LAYER_W = BITWIDTH * NROW,
    localparam int unsigned ADDR_W  = ID_W + COL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    output logic               gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               done,
    output logic [LAYER_W-1:0] result,
    output logic               err,
    output logic               eng_rst,
    input  logic [COL_W-1:0]   eng_col,
    input  logic               eng_ready,
    input  logic [LAYER_W-1:0] eng_result,
    output logic [ADDR_W-1:0]  w_addr
);

    localparam int unsigned WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, KICK, RUN, DONE} state_t;

    state_t             state, state_nxt;
    logic               gnt_nxt, busy_nxt, done_nxt, err_nxt, eng_rst_nxt;
    logic [ID_W-1:0]    gnt_id_nxt, rr_ptr, rr_ptr_nxt, pick_id, ptr_after;
    logic [LAYER_W-1:0] result_nxt;
    logic [WD_W-1:0]    wdog, wdog_nxt;

    // Weight row base is the requester slot; the engine walks the columns inside it.
    assign w_addr = ADDR_W'(gnt_id) * ADDR_W'(NCOL) + ADDR_W'(eng_col);

    assign ptr_after = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);

    // First set request at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic              found;
        logic [ID_W-1:0]   idx;
        found   = 1'b0;
        pick_id = '0;
        idx     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = ID_W'((32'(rr_ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found   = 1'b1;
                pick_id = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
            eng_rst <= 1'b1;
            rr_ptr  <= '0;
            wdog    <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= gnt_id_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            result  <= result_nxt;
            err     <= err_nxt;
            eng_rst <= eng_rst_nxt;
            rr_ptr  <= rr_ptr_nxt;
            wdog    <= wdog_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = 1'b0;
        gnt_id_nxt  = gnt_id;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        result_nxt  = result;
        err_nxt     = 1'b0;
        eng_rst_nxt = 1'b1;
        rr_ptr_nxt  = rr_ptr;
        wdog_nxt    = wdog;
        case (state)
            IDLE: begin
                busy_nxt = 1'b0;
                if (|req) begin
                    gnt_nxt    = 1'b1;
                    gnt_id_nxt = pick_id;
                    busy_nxt   = 1'b1;
                    state_nxt  = KICK;
                end
            end
            KICK: begin
                // Engine sees reset asserted on this edge, then runs from RUN onward.
                wdog_nxt    = '0;
                eng_rst_nxt = 1'b0;
                state_nxt   = RUN;
            end
            RUN: begin
                eng_rst_nxt = 1'b0;
                wdog_nxt    = wdog + WD_W'(1);
                if (eng_ready) begin
                    result_nxt  = eng_result;
                    done_nxt    = 1'b1;
                    eng_rst_nxt = 1'b1;
                    state_nxt   = DONE;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    err_nxt     = 1'b1;
                    busy_nxt    = 1'b0;
                    rr_ptr_nxt  = ptr_after;
                    eng_rst_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            DONE: begin
                busy_nxt   = 1'b0;
                rr_ptr_nxt = ptr_after;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dot_prod_sched.sv
// Scoreboard bench for dot_prod_sched: stimulus pushes expected grant/done/abort events,
// a monitor pops and compares them whenever the scheduler emits one.
module tb_dot_prod_sched;

    localparam int NREQ = 4;
    localparam int LW   = 18 * 16;
    localparam int EV_G = 0;
    localparam int EV_D = 1;
    localparam int EV_E = 2;

    typedef struct {
        int          kind;
        int          id;
        logic [LW-1:0] res;
        int          low;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    req;
    logic          gnt, busy, done, err, eng_rst, eng_ready;
    logic [1:0]    gnt_id, eng_col;
    logic [LW-1:0] result, eng_result;
    logic [3:0]    w_addr;

    int  checks = 0;
    int  errors = 0;
    int  lat    = 0;
    int  salt   = 0;
    int  ecnt   = 0;
    int  low_cnt = 0;
    int  exp_id = 0;
    logic chk_busy_low = 1'b0;
    ev_t sb[$];

    always #5 clk = ~clk;

    dot_prod_sched #(
        .NREQ(4), .NROW(16), .NCOL(4), .BITWIDTH(18), .TIMEOUT(256)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt), .gnt_id(gnt_id),
        .busy(busy), .done(done), .result(result), .err(err), .eng_rst(eng_rst),
        .eng_col(eng_col), .eng_ready(eng_ready), .eng_result(eng_result), .w_addr(w_addr)
    );

    function automatic logic [LW-1:0] mk_res(int id, int s);
        logic [17:0] w;
        w = 18'((id << 12) | (s & 32'hFFF));
        return {16{w}};
    endfunction

    // Engine model: ready pulses in its lat-th cycle out of reset (lat=0 never finishes).
    always @(posedge clk) begin
        if (eng_rst) begin
            ecnt      <= 0;
            eng_ready <= 1'b0;
        end else begin
            ecnt      <= ecnt + 1;
            eng_ready <= (lat >= 2) && (ecnt == lat - 2);
        end
    end
    assign eng_col    = 2'(ecnt);
    assign eng_result = mk_res(int'(gnt_id), salt);

    // Requester drops its bit in the cycle after its done.
    always @(negedge clk) begin
        if (done && !reset) req[gnt_id] = 1'b0;
    end

    always @(negedge clk) begin
        int  kind;
        ev_t ev;
        if (chk_busy_low) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_after_done got=%b want=0", busy);
            end
            chk_busy_low = 1'b0;
        end
        if (gnt || done || err) begin
            kind = gnt ? EV_G : (done ? EV_D : EV_E);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got kind=%0d id=%0d want none", kind, gnt_id);
            end else begin
                ev = sb.pop_front();
                if (kind != ev.kind || int'(gnt_id) != ev.id) begin
                    errors++;
                    $display("FAIL event_order got kind=%0d id=%0d want kind=%0d id=%0d",
                             kind, gnt_id, ev.kind, ev.id);
                end
                if (kind == EV_G) begin
                    exp_id  = ev.id;
                    low_cnt = 0;
                end else begin
                    checks++;
                    if (result !== ev.res) begin
                        errors++;
                        $display("FAIL result got=%h want=%h", result, ev.res);
                    end
                    checks++;
                    if (low_cnt != ev.low) begin
                        errors++;
                        $display("FAIL eng_rst_low_cycles got=%0d want=%0d", low_cnt, ev.low);
                    end
                    if (kind == EV_D) chk_busy_low = 1'b1;
                    else begin
                        checks++;
                        if (busy !== 1'b0) begin
                            errors++;
                            $display("FAIL busy_on_err got=%b want=0", busy);
                        end
                    end
                end
            end
        end
        if (eng_ready && busy) begin
            checks++;
            if (w_addr !== 4'(exp_id * 4 + int'(eng_col))) begin
                errors++;
                $display("FAIL w_addr got=%h want=%h", w_addr, 4'(exp_id * 4 + int'(eng_col)));
            end
        end
        if (!eng_rst) low_cnt++;
    end

    task automatic push(int kind, int id, logic [LW-1:0] res, int low);
        ev_t ev;
        ev.kind = kind;
        ev.id   = id;
        ev.res  = res;
        ev.low  = low;
        sb.push_back(ev);
    endtask

    task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_drain(string nm, int maxc);
        int n = 0;
        while ((sb.size() != 0 || busy || req != 4'b0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got pending=%0d want 0", nm, sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        req   = 4'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", LW'(gnt), LW'(0));
        chk("rst_gnt_id", LW'(gnt_id), LW'(0));
        chk("rst_busy", LW'(busy), LW'(0));
        chk("rst_done", LW'(done), LW'(0));
        chk("rst_result", result, LW'(0));
        chk("rst_err", LW'(err), LW'(0));
        chk("rst_eng_rst", LW'(eng_rst), LW'(1));
        reset = 1'b0;
        @(negedge clk);

        // Single job, 22-cycle engine
        lat = 22; salt = 'hABC;
        push(EV_G, 0, '0, 0);
        push(EV_D, 0, mk_res(0, 'hABC), 22);
        req = 4'b0001;
        @(negedge clk);
        chk("grant_latency", LW'(gnt), LW'(1));
        chk("busy_at_grant", LW'(busy), LW'(1));
        wait_drain("single", 200);

        // All four requesting from pointer 0
        do_reset();
        lat = 5; salt = 1;
        for (int i = 0; i < NREQ; i++) begin
            push(EV_G, i, '0, 0);
            push(EV_D, i, mk_res(i, 1), 5);
        end
        req = 4'b1111;
        wait_drain("all4", 400);

        // Pointer wrap: serve 2, then 0101 grants 0 before 2
        do_reset();
        lat = 3; salt = 2;
        push(EV_G, 2, '0, 0);
        push(EV_D, 2, mk_res(2, 2), 3);
        req = 4'b0100;
        wait_drain("serve2", 100);
        push(EV_G, 0, '0, 0);
        push(EV_D, 0, mk_res(0, 2), 3);
        push(EV_G, 2, '0, 0);
        push(EV_D, 2, mk_res(2, 2), 3);
        req = 4'b0101;
        wait_drain("wrap", 200);

        // Watchdog abort; aborted requester keeps asking but gets lowest priority
        lat = 0;
        push(EV_G, 1, '0, 0);
        push(EV_E, 1, mk_res(2, 2), 256);
        req = 4'b0010;
        n = 0;
        while (!err && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL err_wait got=none want=err");
        end
        lat = 4; salt = 3;
        push(EV_G, 2, '0, 0);
        push(EV_D, 2, mk_res(2, 3), 4);
        push(EV_G, 1, '0, 0);
        push(EV_D, 1, mk_res(1, 3), 4);
        req = 4'b0110;
        wait_drain("after_abort", 200);

        // Reset in the 10th RUN cycle drops the job
        lat = 0; salt = 4;
        push(EV_G, 3, '0, 0);
        req = 4'b1000;
        n = 0;
        while (!gnt && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL gnt_wait got=none want=gnt");
        end
        repeat (10) @(negedge clk);
        reset = 1'b1;
        req   = 4'b0;
        @(negedge clk);
        chk("midrst_eng_rst", LW'(eng_rst), LW'(1));
        chk("midrst_busy", LW'(busy), LW'(0));
        chk("midrst_done", LW'(done), LW'(0));
        chk("midrst_err", LW'(err), LW'(0));
        chk("midrst_gnt_id", LW'(gnt_id), LW'(0));
        reset = 1'b0;
        lat = 6; salt = 5;
        push(EV_G, 1, '0, 0);
        push(EV_D, 1, mk_res(1, 5), 6);
        push(EV_G, 3, '0, 0);
        push(EV_D, 3, mk_res(3, 5), 6);
        req = 4'b1010;
        wait_drain("post_rst", 200);

        // Ready coincides with the last watchdog cycle: ready wins
        lat = 256; salt = 6;
        push(EV_G, 0, '0, 0);
        push(EV_D, 0, mk_res(0, 6), 256);
        req = 4'b0001;
        wait_drain("tie", 1000);

        repeat (3) @(negedge clk);
        chk("sb_empty", LW'(sb.size()), LW'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
